fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction fetch front end that sits directly upstream of the decoder. It issues sequential word fetches to a variable-latency instruction memory and keeps at most one request outstanding. Returned instructions and their PCs go into a small FIFO, which the decoder drains through a valid/ready handshake. Branch/jump redirects flush the queue and squash any in-flight response; halt stops new fetches while the queue still drains.

## Interface
- DEPTH, 4, queue entries; power of two, >= 2
- RESET_ADDR, 16'h0000, first fetch address after reset
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  fetch request; memory samples imem_addr on the edge where imem_req=1
- imem_addr  out  16  word address of the request
- imem_valid  in  1  response strobe for the single outstanding request; earliest 1 cycle after the request edge
- imem_instr  in  16  returned instruction; valid when imem_valid=1
- redirect  in  1  flush and restart fetch at redirect_addr (taken branch/jump from decode)
- redirect_addr  in  16  new fetch address
- hlt  in  1  level; while 1, no new requests are issued
- id_valid  out  1  queue head is valid
- id_instr  out  16  head instruction
- id_pc  out  16  head instruction address (decoder forms branch base as id_pc+1)
- id_ready  in  1  decoder accepts head; pop when id_valid & id_ready
- empty  out  1  count==0
- full  out  1  count==DEPTH

## Operation
- State: fetch_pc[15:0], req_pc[15:0], FIFO (instr+pc per entry), rd_ptr/wr_ptr (log2 DEPTH bits, wrap modulo DEPTH), count (0..DEPTH), FSM {FETCH, WAIT, SQUASH}.
- Space condition: count + (state!=FETCH) < DEPTH. An outstanding request always has a reserved slot, so no response is ever dropped for lack of room.
- FETCH: imem_req = space & !hlt & !redirect; imem_addr = fetch_pc. On a request edge: req_pc<=fetch_pc, fetch_pc<=fetch_pc+1 (16-bit wrap, FFFF->0000), go to WAIT.
- WAIT: imem_req=0. On imem_valid: push {imem_instr, req_pc}, go to FETCH.
- SQUASH: imem_req=0. On imem_valid: discard the data, go to FETCH.
- Pop: when id_valid & id_ready, rd_ptr++ and count--. A push and a pop in the same cycle leave count unchanged.
- Redirect (priority over push, pop and request):
  - count<=0; rd_ptr<=wr_ptr<=0; fetch_pc<=redirect_addr.
  - In WAIT with imem_valid=0, go to SQUASH.
  - In WAIT with imem_valid=1, drop the response and go to FETCH.
  - In SQUASH, stay in SQUASH unless imem_valid=1, in which case go to FETCH.
  - In FETCH, stay in FETCH; no request is issued that cycle.
- hlt: blocks only new requests. An outstanding request still completes and is pushed. Pops continue. Redirect is still honoured.
- id_instr/id_pc are read combinationally from the head entry. When empty, their value is don't-care and id_valid=0.
- imem_valid in FETCH state is a protocol violation and is ignored.

## Timing
- Reset, sampled on an edge with rst=1: state=FETCH, fetch_pc=RESET_ADDR, count=0, pointers=0.
  - Outputs: imem_req=0 while rst=1, id_valid=0, empty=1, full=0.
  - imem_req may assert in the first cycle with rst=0.
- Reset mid-operation: an outstanding response arriving after reset is a protocol violation. The memory is reset with the same rst.
- Memory latency L>=1 cycles: request at edge t, response sampled at edge t+L, entry visible (id_valid=1) after edge t+L. The next request can be made no earlier than the cycle after edge t+L. Peak throughput is 1 instruction per L+1 cycles.
- Redirect sampled at edge t: id_valid=0 after t. The first request to redirect_addr is made at edge t+1 from FETCH, or one cycle after the squashed response.
- full/empty/id_valid are registered-state derived and update on the same edge as count.

## Test plan
- Reset then free-run, L=1, id_ready=1, memory returns addr^16'hA5A5:
  - requests at addresses 0,1,2,… every 2 cycles;
  - decoder sees id_pc 0,1,2 with id_instr A5A5,A5A4,A5A7.
- Back-pressure, id_ready=0, L=1: exactly DEPTH=4 requests (0..3) issue, then imem_req stays 0, full=1. Raising id_ready for one cycle pops pc 0, and a request for address 4 follows.
- Redirect during WAIT, L=3:
  - request to 5 outstanding; redirect to 16'h0040 the next cycle;
  - the response for 5 is discarded; the next request is to 0040; the first id_pc after the redirect is 0040.
- Redirect coincident with imem_valid and a pop: queue empties, response dropped, the next request is to redirect_addr on the following edge, id_valid=0 for at least 2 cycles.
- hlt raised while a request is outstanding: that response is pushed, no further imem_req, and the queue drains to empty=1. Lowering hlt resumes at the next sequential address.
- Wrap-around: with RESET_ADDR=16'hFFFE, fetches go FFFE, FFFF, 0000, 0001 with matching id_pc. The FIFO pointers also wrap after more than DEPTH pushes, with data order preserved.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Fetch front-end bundle: instruction memory port, redirect/halt controls and decode handshake.
interface fetch_queue_if;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_valid;
    logic [15:0] imem_instr;
    logic        redirect;
    logic [15:0] redirect_addr;
    logic        hlt;
    logic        id_valid;
    logic [15:0] id_instr;
    logic [15:0] id_pc;
    logic        id_ready;
    logic        empty;
    logic        full;

    modport master (
        output imem_req, imem_addr, id_valid, id_instr, id_pc, empty, full,
        input  imem_valid, imem_instr, redirect, redirect_addr, hlt, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, id_valid, id_instr, id_pc, empty, full,
        output imem_valid, imem_instr, redirect, redirect_addr, hlt, id_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// Sequential instruction fetch with a single outstanding memory request, feeding a small
// FIFO that the decoder drains. Redirect flushes the FIFO and squashes any in-flight response.
module fetch_queue #(
    parameter int          DEPTH      = 4,
    parameter logic [15:0] RESET_ADDR = 16'h0000
) (
    input logic           clk,
    input logic           rst,
    fetch_queue_if.master bus
);
    localparam int            PW        = $clog2(DEPTH);
    localparam logic [PW:0]   DEPTH_CNT = (PW+1)'(DEPTH);
    localparam logic [PW+1:0] DEPTH_OCC = (PW+2)'(DEPTH);

    typedef enum logic [1:0] {FETCH, WAIT, SQUASH} state_t;

    state_t        state, state_nxt;
    logic [15:0]   fetch_pc, req_pc;
    logic [15:0]   buf_instr [DEPTH];
    logic [15:0]   buf_pc    [DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [PW:0]   count;
    logic [PW+1:0] occupancy;
    logic          space, req, push, pop, head_valid;

    // A request in flight (even a squashed one) holds a reserved slot.
    assign occupancy  = {1'b0, count} + {{(PW+1){1'b0}}, state != FETCH};
    assign space      = occupancy < DEPTH_OCC;
    assign head_valid = count != '0;
    assign pop        = head_valid && bus.id_ready;

    always_comb begin
        state_nxt = state;
        req       = 1'b0;
        push      = 1'b0;
        unique case (state)
            FETCH: begin
                req = space && !bus.hlt && !bus.redirect && !rst;
                if (req) state_nxt = WAIT;
            end
            WAIT: begin
                if (bus.imem_valid) begin
                    state_nxt = FETCH;
                    push      = !bus.redirect;
                end else if (bus.redirect) begin
                    state_nxt = SQUASH;
                end
            end
            SQUASH: begin
                if (bus.imem_valid) state_nxt = FETCH;
            end
            default: state_nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH;
            fetch_pc <= RESET_ADDR;
            req_pc   <= RESET_ADDR;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            state <= state_nxt;
            if (bus.redirect) begin
                fetch_pc <= bus.redirect_addr;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
            end else begin
                if (req) begin
                    req_pc   <= fetch_pc;
                    fetch_pc <= fetch_pc + 16'd1;
                end
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
            end
        end
    end

    // Storage needs no reset; head data is ignored while the queue is empty.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            buf_instr[wr_ptr] <= bus.imem_instr;
            buf_pc[wr_ptr]    <= req_pc;
        end
    end

    assign bus.imem_req  = req;
    assign bus.imem_addr = fetch_pc;
    assign bus.id_valid  = head_valid;
    assign bus.id_instr  = buf_instr[rd_ptr];
    assign bus.id_pc     = buf_pc[rd_ptr];
    assign bus.empty     = count == '0;
    assign bus.full      = count == DEPTH_CNT;
endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue: a behavioural memory plus a fetch-stream model feed a
// scoreboard; a separate monitor checks request legality, queue flags and every decoded word.
module tb_fetch_queue;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] instr;
    } entry_t;

    logic clk = 1'b0;
    logic rst;

    fetch_queue_if bus ();
    fetch_queue_if bus_b ();

    fetch_queue #(.DEPTH(DEPTH), .RESET_ADDR(16'h0000)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    fetch_queue #(.DEPTH(DEPTH), .RESET_ADDR(16'hFFFE)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    entry_t      sb[$];
    logic [15:0] exp_pc = 16'h0000;
    bit          mem_busy = 1'b0;
    bit          mem_squash = 1'b0;
    int          mem_cnt = 0;
    logic [15:0] mem_addr = 16'h0000;
    int          lat_lo, lat_hi, p_ready, p_redir, p_hlt;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a ^ 16'hA5A5;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; afterwards the model reflects the state following the next edge.
    task automatic cycle(input bit do_rst, input bit force_redir, input logic [15:0] force_addr);
        @(negedge clk);
        rst               = do_rst;
        bus.id_ready      = ($urandom_range(99) < p_ready);
        bus.hlt           = ($urandom_range(99) < p_hlt);
        bus.redirect      = !do_rst && (force_redir || ($urandom_range(99) < p_redir));
        bus.redirect_addr = force_redir ? force_addr : 16'($urandom);
        bus.imem_valid    = !do_rst && mem_busy && (mem_cnt == 1);
        bus.imem_instr    = bus.imem_valid ? mem_word(mem_addr) : 16'($urandom);
        #2;
        if (do_rst) begin
            sb.delete();
            mem_busy   = 1'b0;
            mem_squash = 1'b0;
            exp_pc     = 16'h0000;
        end else begin
            if (bus.imem_valid) begin
                if (!mem_squash && !bus.redirect) sb.push_back({mem_addr, mem_word(mem_addr)});
                mem_busy = 1'b0;
            end else if (mem_busy && mem_cnt > 1) begin
                mem_cnt--;
            end
            if (bus.redirect) begin
                sb.delete();
                exp_pc = bus.redirect_addr;
                if (mem_busy) mem_squash = 1'b1;
            end
            if (bus.imem_req) begin
                mem_busy   = 1'b1;
                mem_squash = 1'b0;
                mem_cnt    = int'($urandom_range(lat_hi, lat_lo));
                mem_addr   = bus.imem_addr;
                exp_pc     = exp_pc + 16'd1;
            end
        end
    endtask

    task automatic redirect_in_wait(input logic [15:0] addr);
        int n = 0;
        while (!mem_busy && n < 10) begin
            cycle(1'b0, 1'b0, 16'h0);
            n++;
        end
        check("redirect_setup_busy", 32'(mem_busy), 32'(1));
        cycle(1'b0, 1'b1, addr);
    endtask

    // Monitor: legality of the request, queue flags, and scoreboard pop on each handshake.
    initial begin
        entry_t e;
        bit     exp_req;
        forever begin
            @(negedge clk);
            #1;
            exp_req = !rst && !mem_busy && (sb.size() < DEPTH) && !bus.hlt && !bus.redirect;
            check("imem_req", 32'(bus.imem_req), 32'(exp_req));
            if (exp_req && bus.imem_req) check("imem_addr", 32'(bus.imem_addr), 32'(exp_pc));
            check("id_valid", 32'(bus.id_valid), 32'(sb.size() != 0));
            check("empty", 32'(bus.empty), 32'(sb.size() == 0));
            check("full", 32'(bus.full), 32'(sb.size() == DEPTH));
            if (!rst && !bus.redirect && bus.id_valid && bus.id_ready && sb.size() != 0) begin
                e = sb.pop_front();
                check("id_pc", 32'(bus.id_pc), 32'(e.pc));
                check("id_instr", 32'(bus.id_instr), 32'(e.instr));
            end
        end
    end

    initial begin
        rst                 = 1'b1;
        bus.imem_valid      = 1'b0;
        bus.imem_instr      = 16'h0;
        bus.redirect        = 1'b0;
        bus.redirect_addr   = 16'h0;
        bus.hlt             = 1'b0;
        bus.id_ready        = 1'b0;
        bus_b.imem_valid    = 1'b0;
        bus_b.imem_instr    = 16'h0;
        bus_b.redirect      = 1'b0;
        bus_b.redirect_addr = 16'h0;
        bus_b.hlt           = 1'b0;
        bus_b.id_ready      = 1'b1;
        p_ready = 100; p_redir = 0; p_hlt = 0; lat_lo = 1; lat_hi = 1;

        repeat (3) cycle(1'b1, 1'b0, 16'h0);
        cycle(1'b0, 1'b0, 16'h0);
        check("b_reset_req", 32'(bus_b.imem_req), 32'(1));
        check("b_reset_addr", 32'(bus_b.imem_addr), 32'h0000FFFE);

        // Free run at L=1, then back-pressure until full, then single pops.
        repeat (24) cycle(1'b0, 1'b0, 16'h0);
        p_ready = 0;
        repeat (16) cycle(1'b0, 1'b0, 16'h0);
        check("full_after_backpressure", 32'(bus.full), 32'(1));
        repeat (3) begin
            p_ready = 100; cycle(1'b0, 1'b0, 16'h0);
            p_ready = 0;   repeat (5) cycle(1'b0, 1'b0, 16'h0);
        end
        p_ready = 100;

        // Redirects while a slow response is outstanding.
        lat_lo = 3; lat_hi = 3;
        repeat (4) cycle(1'b0, 1'b0, 16'h0);
        redirect_in_wait(16'h0040);
        repeat (12) cycle(1'b0, 1'b0, 16'h0);
        lat_lo = 1; lat_hi = 1;
        redirect_in_wait(16'h1230);
        repeat (8) cycle(1'b0, 1'b0, 16'h0);

        // Halt drains the queue, then fetch resumes sequentially.
        lat_lo = 2; lat_hi = 2;
        repeat (3) cycle(1'b0, 1'b0, 16'h0);
        p_hlt = 100;
        repeat (20) cycle(1'b0, 1'b0, 16'h0);
        check("empty_after_hlt", 32'(bus.empty), 32'(1));
        p_hlt = 0;
        repeat (10) cycle(1'b0, 1'b0, 16'h0);

        // Address wrap past FFFF with FIFO pointer wrap.
        lat_lo = 1; lat_hi = 1;
        cycle(1'b0, 1'b1, 16'hFFFE);
        repeat (30) cycle(1'b0, 1'b0, 16'h0);

        // Random traffic, mid-run reset, more random traffic.
        lat_lo = 1; lat_hi = 4; p_ready = 60; p_redir = 5; p_hlt = 15;
        repeat (1500) cycle(1'b0, 1'b0, 16'h0);
        repeat (2) cycle(1'b1, 1'b0, 16'h0);
        p_ready = 80; p_redir = 3; p_hlt = 10; lat_hi = 2;
        repeat (500) cycle(1'b0, 1'b0, 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
